fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write-side scheduler that shares one FIFO write port among N packet requesters. Each requester offers beats on a valid/ready handshake and holds the grant until the beat flagged last is accepted. Beats go to the FIFO through a registered wen/din stage, throttled by the FIFO's full and almost_full flags. Sits in the write clock domain, directly in front of the FIFO's write port.

## Interface
- N, 4: number of requesters (2..16).
- W, 8: data width per beat.
- clk  in  1  write-domain clock.
- resetn  in  1  synchronous, active-low reset.
- req_valid  in  N  per-requester beat valid.
- req_data  in  N*W  requester i's beat in bits [i*W +: W].
- req_last  in  N  per-requester last-beat-of-packet flag.
- req_ready  out  N  per-requester accept; at most one bit high.
- cfg_enable  in  N  per-requester arbitration enable mask.
- fifo_full  in  1  FIFO full, write-domain view.
- fifo_almost_full  in  1  exactly one free slot left.
- fifo_wen  out  1  registered FIFO write enable.
- fifo_din  out  W  registered FIFO write data.
- grant_valid  out  1  a requester currently holds the grant.
- grant_id  out  $clog2(N)  index of the granted requester.

## Operation
- States: IDLE and LOCKED.
- IDLE:
  - Candidates are requesters with req_valid[i] && cfg_enable[i].
  - If any candidate exists, pick the first one searching from (last_id+1) mod N upward with wrap. Register grant_id to the pick and go to LOCKED.
  - If none, stay in IDLE.
  - req_ready is all zero in IDLE.
- LOCKED:
  - accept = req_valid[g] && !fifo_full && !(fifo_wen && fifo_almost_full).
  - req_ready[g] = !fifo_full && !(fifo_wen && fifo_almost_full); all other ready bits are 0.
  - A beat is accepted when req_valid[g] && req_ready[g].
  - On an accepted beat with req_last[g]: last_id <= g, go to IDLE.
- cfg_enable affects only IDLE selection. Clearing a granted requester's enable mid-packet does not abort the packet.
- The requester's valid may drop mid-packet. The grant is held with no timeout.
- Every accepted beat produces exactly one fifo_wen pulse. fifo_wen is never asserted when the write would overflow.
- Reset mid-packet: packet is abandoned, no further writes, last_id returns to N-1.

## Timing
- Reset values: state IDLE, last_id N-1 (so requester 0 wins first), grant_valid 0, grant_id 0, req_ready 0, fifo_wen 0, fifo_din 0.
- Grant latency: 1 cycle from the candidate's valid in IDLE to grant_valid / req_ready.
- Write latency: a beat accepted in cycle t gives fifo_wen=1 and fifo_din=beat in cycle t+1.
- fifo_din holds its last value when fifo_wen=0.
- Throughput: 1 beat/cycle while LOCKED and the FIFO is not near full.
- Packet-to-packet gap: 1 bubble cycle (the IDLE arbitration cycle).
- Full lookahead: when fifo_wen=1 and fifo_almost_full=1 in the same cycle, ready drops that cycle. The pending write fills the last slot.
- A single-beat packet (valid && last on its first accepted beat) occupies LOCKED for exactly one cycle.

## Structure
- Package fifo_arb_pkg:
  - State enum typedef (IDLE, LOCKED).
  - Function computing the grant-index width, $clog2(N) with a minimum of 1.
- Sub-module rr_pick: combinational round-robin priority pick.
  - Inputs: N-bit candidate vector, start index.
  - Outputs: found flag, winning index.
  - Implement as a doubled-vector or rotate/priority/unrotate scheme.
- Top level: FSM, grant and last_id registers, req_ready decode, data mux, registered wen/din stage.

## Test plan
- Reset then requesters 0 and 2 both valid with single-beat packets (A0, C0):
  - grant_id goes 0 then 2.
  - fifo_din sequence is A0, C0.
  - fifo_wen pulses in cycles 2 and 4 after reset release.
- Requester 1 sends 4-beat packet 0x10..0x13 while requester 3 is valid throughout:
  - No req_ready[3] until 0x13 is accepted.
  - The FIFO receives 0x10, 0x11, 0x12, 0x13, then requester 3's beats.
- FIFO model depth 4 with the reader stalled, one 6-beat packet:
  - Exactly 4 wen pulses.
  - req_ready falls in the cycle the 4th write is pending.
  - Releasing one read slot yields exactly one more accepted beat.
- cfg_enable = 4'b1011 with all four requesters valid: grant rotation is 0, 1, 3, 0; requester 2 is never granted.
- Assert resetn low mid-packet (after 2 of 5 beats):
  - Next cycle fifo_wen=0, grant_valid=0.
  - After release, requester 0 is granted first.
- Requester 2 drops valid for 3 cycles mid-packet while requester 0 is valid:
  - grant_id stays 2 throughout.
  - No wen pulses during the gap.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and helpers for the FIFO write-side arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Arbiter FSM states: IDLE arbitrates, LOCKED streams one packet.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int grant_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter_if
// Description : Requester handshake, FIFO write port and grant status bundle.
//               slave  = arbiter side, master = requesters/FIFO side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) ();
    localparam int GW = grant_width(N);

    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   cfg_enable;
    logic           fifo_full;
    logic           fifo_almost_full;
    logic           fifo_wen;
    logic [W-1:0]   fifo_din;
    logic           grant_valid;
    logic [GW-1:0]  grant_id;

    modport slave (
        input  req_valid, req_data, req_last, cfg_enable,
        input  fifo_full, fifo_almost_full,
        output req_ready, fifo_wen, fifo_din, grant_valid, grant_id
    );

    modport master (
        output req_valid, req_data, req_last, cfg_enable,
        output fifo_full, fifo_almost_full,
        input  req_ready, fifo_wen, fifo_din, grant_valid, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin pick. Finds the first set bit of
//               i_cand searching from i_start upward with wrap-around, using
//               a doubled vector shifted down by the start index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int GW = 2
) (
    input  wire  [N-1:0]  i_cand,
    input  wire  [GW-1:0] i_start,
    output logic          o_found,
    output logic [GW-1:0] o_idx
);
    localparam int            SW  = GW + 1;
    localparam logic [GW:0]   C_N = SW'(N);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [GW-1:0]  w_off;
    logic [GW:0]    w_sum;

    // Bit k of w_rot is candidate (i_start + k) mod N.
    assign w_dbl = {i_cand, i_cand};
    assign w_rot = N'(w_dbl >> i_start);

    // Lowest set bit of the rotated vector is the nearest candidate.
    always_comb begin
        o_found = 1'b0;
        w_off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_found = 1'b1;
                w_off   = GW'(i);
            end
        end
    end

    // Map the rotated offset back to an absolute requester index.
    always_comb begin
        w_sum = {1'b0, i_start} + {1'b0, w_off};
        if (w_sum >= C_N) begin
            o_idx = GW'(w_sum - C_N);
        end else begin
            o_idx = w_sum[GW-1:0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin packet arbiter sharing one FIFO write port among
//               N requesters. Grant is held until the last beat is accepted;
//               beats reach the FIFO through a registered wen/din stage with
//               one-slot lookahead on almost_full.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input wire                 clk,
    input wire                 resetn,
    fifo_write_arbiter_if.slave bus
);
    localparam int            GW            = grant_width(N);
    localparam logic [GW-1:0] C_LAST_ID_RST = GW'(N - 1);

    arb_state_t    state_q,    state_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [GW-1:0] last_id_q,  last_id_d;
    logic          wen_q,      wen_d;
    logic [W-1:0]  din_q,      din_d;

    logic [N-1:0]  w_cand;
    logic [GW-1:0] w_start;
    logic          w_found;
    logic [GW-1:0] w_pick;
    logic          w_locked;
    logic          w_space;
    logic          w_accept;
    logic [W-1:0]  w_beat;
    logic          w_beat_last;
    logic [N-1:0]  w_ready;

    // Search starts just after the requester that finished most recently.
    assign w_cand  = bus.req_valid & bus.cfg_enable;
    assign w_start = (last_id_q == C_LAST_ID_RST) ? '0 : last_id_q + GW'(1);

    rr_pick #(
        .N  (N),
        .GW (GW)
    ) u_rr_pick (
        .i_cand  (w_cand),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // A write pending into the last free slot counts as full this cycle.
    assign w_locked    = (state_q == ST_LOCKED);
    assign w_space     = !bus.fifo_full && !(wen_q && bus.fifo_almost_full);
    assign w_beat      = bus.req_data[int'(grant_id_q) * W +: W];
    assign w_beat_last = bus.req_last[grant_id_q];
    assign w_accept    = w_locked && bus.req_valid[grant_id_q] && w_space;

    // Only the granted requester may see ready, and only while there is room.
    always_comb begin
        w_ready = '0;
        if (w_locked) begin
            w_ready[grant_id_q] = w_space;
        end
    end

    // Next-state: arbitrate in IDLE, stream beats and release on last in LOCKED.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        wen_d      = 1'b0;
        din_d      = din_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    grant_id_d = w_pick;
                    state_d    = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_accept) begin
                    wen_d = 1'b1;
                    din_d = w_beat;
                    if (w_beat_last) begin
                        last_id_d = grant_id_q;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant bookkeeping and the FIFO write stage.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            last_id_q  <= C_LAST_ID_RST;
            wen_q      <= 1'b0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            wen_q      <= wen_d;
            din_q      <= din_d;
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.fifo_wen    = wen_q;
    assign bus.fifo_din    = din_q;
    assign bus.grant_valid = w_locked;
    assign bus.grant_id    = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Self-checking bench for fifo_write_arbiter: directed vector
//               table, directed corner sequences and randomized traffic
//               against a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] rdy;
        logic         gv;
        int           gid;
        logic         wen;
        logic [W-1:0] din;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;

    fifo_write_arbiter_if #(.N(N), .W(W)) bus ();

    fifo_write_arbiter #(.N(N), .W(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Environment state
    beat_t        rq [N][$];
    logic [N-1:0] hold;
    logic [N-1:0] en;
    logic         full_i, af_i;
    bit           fifo_mode;
    int           fcount;
    bit           rd;
    bit           manual;
    logic [N-1:0] man_v;
    bit           chk_en;

    // Reference model state
    bit           m_locked;
    int           m_owner;
    int           m_last;
    bit           m_wen;
    logic [W-1:0] m_din;

    // Observation logs
    logic [W-1:0] wr_log [$];
    int           gnt_log [$];
    bit           prev_gv;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (manual) begin
                bus.req_valid[i]        = man_v[i];
                bus.req_last[i]         = 1'b1;
                bus.req_data[i*W +: W]  = (i == 0) ? 8'hA0 : (i == 2) ? 8'hC0 : 8'h00;
            end else if (rq[i].size() > 0 && !hold[i]) begin
                bus.req_valid[i]        = 1'b1;
                bus.req_data[i*W +: W]  = rq[i][0].d;
                bus.req_last[i]         = rq[i][0].l;
            end else begin
                bus.req_valid[i]        = 1'b0;
                bus.req_data[i*W +: W]  = '0;
                bus.req_last[i]         = 1'b0;
            end
        end
        bus.cfg_enable = en;
        if (fifo_mode) begin
            bus.fifo_full        = (fcount >= DEPTH);
            bus.fifo_almost_full = (fcount == DEPTH - 1);
        end else begin
            bus.fifo_full        = full_i;
            bus.fifo_almost_full = af_i;
        end
    endtask

    function automatic bit model_space();
        return !bus.fifo_full && !(m_wen && bus.fifo_almost_full);
    endfunction

    task automatic model_check();
        logic [31:0] exp_rdy;
        exp_rdy = (m_locked && model_space()) ? (32'd1 << m_owner) : 32'd0;
        chk("req_ready",   32'(bus.req_ready),   exp_rdy);
        chk("grant_valid", 32'(bus.grant_valid), 32'(m_locked));
        chk("grant_id",    32'(bus.grant_id),    32'(m_owner));
        chk("fifo_wen",    32'(bus.fifo_wen),    32'(m_wen));
        chk("fifo_din",    32'(bus.fifo_din),    32'(m_din));
        if (fifo_mode) begin
            chk("no_overflow", 32'(bus.fifo_wen && fcount >= DEPTH), 32'd0);
        end
    endtask

    // Packet-level rules: owner streams until last; then round-robin search.
    task automatic model_step();
        bit acc;
        bit found;
        int idx;
        if (!resetn) begin
            m_locked = 0; m_owner = 0; m_last = N - 1; m_wen = 0; m_din = '0;
        end else if (m_locked) begin
            acc   = bus.req_valid[m_owner] && model_space();
            m_wen = acc;
            if (acc) begin
                m_din = bus.req_data[m_owner*W +: W];
                if (bus.req_last[m_owner]) begin
                    m_locked = 0;
                    m_last   = m_owner;
                end
            end
        end else begin
            m_wen = 0;
            found = 0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (!found && bus.req_valid[idx] && bus.cfg_enable[idx]) begin
                    found    = 1;
                    m_locked = 1;
                    m_owner  = idx;
                end
            end
        end
    endtask

    task automatic cyc();
        logic [N-1:0] rdy, vld;
        bit           wen_now;
        bit           rst_now;
        #1;
        if (chk_en) model_check();
        if (bus.fifo_wen === 1'b1) wr_log.push_back(bus.fifo_din);
        if (bus.grant_valid === 1'b1 && !prev_gv) gnt_log.push_back(int'(bus.grant_id));
        prev_gv = (bus.grant_valid === 1'b1);
        rdy     = bus.req_ready;
        vld     = bus.req_valid;
        wen_now = m_wen;
        rst_now = resetn;
        model_step();
        @(posedge clk);
        if (rst_now && !manual) begin
            for (int i = 0; i < N; i++) begin
                if (rdy[i] === 1'b1 && vld[i]) void'(rq[i].pop_front());
            end
        end
        if (fifo_mode) fcount = fcount + int'(wen_now) - int'(rd);
        #1;
        drive();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        chk_en = 0;
        for (int i = 0; i < N; i++) rq[i].delete();
        hold = '0; en = '1; full_i = 0; af_i = 0;
        fifo_mode = 0; fcount = 0; rd = 0; manual = 0;
        drive();
        cyc();
        cyc();
        chk_en = 1;
        cyc();
        resetn = 1'b1;
        drive();
        wr_log.delete();
        gnt_log.delete();
        prev_gv = 0;
    endtask

    task automatic push_pkt(input int r, input logic [W-1:0] base, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = base + W'(k);
            b.l = (k == len - 1);
            rq[r].push_back(b);
        end
    endtask

    vec_t tbl [6];

    initial begin
        bit reached;
        int n2;

        // Two single-beat packets on requesters 0 and 2, cycle by cycle.
        tbl[0] = '{v: 4'b0101, rdy: 4'b0000, gv: 0, gid: 0, wen: 0, din: 8'h00};
        tbl[1] = '{v: 4'b0101, rdy: 4'b0001, gv: 1, gid: 0, wen: 0, din: 8'h00};
        tbl[2] = '{v: 4'b0100, rdy: 4'b0000, gv: 0, gid: 0, wen: 1, din: 8'hA0};
        tbl[3] = '{v: 4'b0100, rdy: 4'b0100, gv: 1, gid: 2, wen: 0, din: 8'hA0};
        tbl[4] = '{v: 4'b0000, rdy: 4'b0000, gv: 0, gid: 2, wen: 1, din: 8'hC0};
        tbl[5] = '{v: 4'b0000, rdy: 4'b0000, gv: 0, gid: 2, wen: 0, din: 8'hC0};

        resetn = 1'b0;
        m_locked = 0; m_owner = 0; m_last = N - 1; m_wen = 0; m_din = '0;
        man_v = '0;

        // ---------------- Directed table ----------------
        do_reset();
        manual = 1;
        for (int r = 0; r < 6; r++) begin
            man_v = tbl[r].v;
            drive();
            #1;
            chk("tbl_ready", 32'(bus.req_ready),   32'(tbl[r].rdy));
            chk("tbl_gv",    32'(bus.grant_valid), 32'(tbl[r].gv));
            chk("tbl_gid",   32'(bus.grant_id),    32'(tbl[r].gid));
            chk("tbl_wen",   32'(bus.fifo_wen),    32'(tbl[r].wen));
            chk("tbl_din",   32'(bus.fifo_din),    32'(tbl[r].din));
            cyc();
        end
        manual = 0;

        // ---------------- Packet lock vs competing requester ----------------
        do_reset();
        push_pkt(1, 8'h10, 4);
        push_pkt(3, 8'h30, 2);
        drive();
        for (int c = 0; c < 20; c++) begin
            #1;
            if (rq[1].size() > 0) chk("ready3_blocked", 32'(bus.req_ready[3]), 32'd0);
            cyc();
        end
        chk("lock_wr_count", 32'(wr_log.size()), 32'd6);
        if (wr_log.size() == 6) begin
            chk("lock_wr0", 32'(wr_log[0]), 32'h10);
            chk("lock_wr1", 32'(wr_log[1]), 32'h11);
            chk("lock_wr2", 32'(wr_log[2]), 32'h12);
            chk("lock_wr3", 32'(wr_log[3]), 32'h13);
            chk("lock_wr4", 32'(wr_log[4]), 32'h30);
            chk("lock_wr5", 32'(wr_log[5]), 32'h31);
        end

        // ---------------- FIFO back-pressure, depth 4, reader stalled ----------------
        do_reset();
        fifo_mode = 1;
        push_pkt(0, 8'h40, 6);
        drive();
        for (int c = 0; c < 12; c++) cyc();
        chk("full_wen_count", 32'(wr_log.size()), 32'd4);
        rd = 1;
        cyc();
        rd = 0;
        for (int c = 0; c < 8; c++) cyc();
        chk("one_slot_wen_count", 32'(wr_log.size()), 32'd5);
        for (int c = 0; c < 20; c++) begin
            rd = (fcount > 0);
            cyc();
        end
        rd = 0;
        chk("drain_wen_count", 32'(wr_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < wr_log.size(); k++)
            chk("drain_data", 32'(wr_log[k]), 32'h40 + 32'(k));
        fifo_mode = 0;

        // ---------------- Enable mask rotation ----------------
        do_reset();
        en = 4'b1011;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++) push_pkt(i, W'(i * 16 + k), 1);
        drive();
        for (int c = 0; c < 16; c++) cyc();
        chk("rot_count", 32'(gnt_log.size() >= 4), 32'd1);
        if (gnt_log.size() >= 4) begin
            chk("rot0", 32'(gnt_log[0]), 32'd0);
            chk("rot1", 32'(gnt_log[1]), 32'd1);
            chk("rot2", 32'(gnt_log[2]), 32'd3);
            chk("rot3", 32'(gnt_log[3]), 32'd0);
        end
        n2 = 0;
        foreach (gnt_log[k]) if (gnt_log[k] == 2) n2++;
        chk("rot_no_req2", 32'(n2), 32'd0);

        // ---------------- Reset mid-packet ----------------
        do_reset();
        push_pkt(1, 8'h51, 1);
        push_pkt(2, 8'h60, 5);
        drive();
        reached = 0;
        for (int c = 0; c < 30 && !reached; c++) begin
            cyc();
            if (rq[2].size() == 3) reached = 1;
        end
        chk("rst_reach_2beats", 32'(reached), 32'd1);
        push_pkt(0, 8'h70, 1);
        resetn = 1'b0;
        drive();
        cyc();
        #1;
        chk("rst_wen",  32'(bus.fifo_wen),    32'd0);
        chk("rst_gv",   32'(bus.grant_valid), 32'd0);
        resetn = 1'b1;
        drive();
        gnt_log.delete();
        prev_gv = 0;
        for (int c = 0; c < 6; c++) cyc();
        chk("rst_first_grant_seen", 32'(gnt_log.size() > 0), 32'd1);
        if (gnt_log.size() > 0) chk("rst_first_grant", 32'(gnt_log[0]), 32'd0);

        // ---------------- Valid gap mid-packet ----------------
        do_reset();
        push_pkt(2, 8'h80, 6);
        drive();
        reached = 0;
        for (int c = 0; c < 20 && !reached; c++) begin
            cyc();
            if (rq[2].size() == 4) reached = 1;
        end
        chk("gap_reach_2beats", 32'(reached), 32'd1);
        push_pkt(0, 8'h90, 1);
        hold[2] = 1'b1;
        drive();
        for (int h = 0; h < 3; h++) begin
            #1;
            chk("gap_gid", 32'(bus.grant_id),    32'd2);
            chk("gap_gv",  32'(bus.grant_valid), 32'd1);
            if (h > 0) chk("gap_wen", 32'(bus.fifo_wen), 32'd0);
            cyc();
        end
        hold[2] = 1'b0;
        drive();
        #1;
        chk("gap_wen_end", 32'(bus.fifo_wen), 32'd0);
        for (int c = 0; c < 15; c++) cyc();
        chk("gap_wr_count", 32'(wr_log.size()), 32'd7);
        if (wr_log.size() == 7) begin
            for (int k = 0; k < 6; k++) chk("gap_wr", 32'(wr_log[k]), 32'h80 + 32'(k));
            chk("gap_wr_req0", 32'(wr_log[6]), 32'h90);
        end

        // ---------------- Randomized traffic ----------------
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() == 0 && $urandom_range(2) == 0)
                    push_pkt(i, W'($urandom_range(255)), int'($urandom_range(1, 4)));
                hold[i] = ($urandom_range(4) == 0);
            end
            if ($urandom_range(7) == 0) en = N'($urandom_range(15));
            full_i = ($urandom_range(5) == 0);
            af_i   = !full_i && ($urandom_range(3) == 0);
            resetn = ($urandom_range(149) != 0);
            drive();
            cyc();
        end
        resetn = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
